// File: rtl/mac_rx_byte_unpacker.sv
// mac_rx_byte_unpacker: reads 32-bit MAC receive words and re-emits each frame as a byte stream
module mac_rx_byte_unpacker (
  input  logic        Clk_user,
  input  logic        Reset,
  input  logic        Rx_mac_ra,
  output logic        Rx_mac_rd,
  input  logic [31:0] Rx_mac_data,
  input  logic [1:0]  Rx_mac_BE,
  input  logic        Rx_mac_pa,
  input  logic        Rx_mac_sop,
  input  logic        Rx_mac_eop,
  output logic [7:0]  Rx_byte_data,
  output logic        Rx_byte_valid,
  input  logic        Rx_byte_ready,
  output logic        Rx_byte_sop,
  output logic        Rx_byte_eop,
  output logic        Rx_byte_abort,
  output logic [15:0] Rx_frame_len,
  output logic        Rx_frame_len_valid,
  output logic [15:0] Rx_err_cnt
);
  localparam logic [1:0] WAIT_SOP = 2'd0, IN_FRAME = 2'd1, DISCARD = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [1:0]  occ_q, occ_d;
  logic        infl_q;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] dat_q [2];
  logic [31:0] dat_d [2];
  logic [1:0]  nbm1_q [2];
  logic [1:0]  nbm1_d [2];
  logic [1:0]  sop_q, sop_d, eop_q, eop_d, abt_q, abt_d;
  logic [15:0] len_q, len_d, len_nxt, flen_q, flen_d, err_q, err_d;
  logic        flv_q, flv_d;
  logic        accept, push, push_abt, err_inc, fire, pop, head_v;
  assign Rx_mac_rd = Rx_mac_ra & ~Reset & (({1'b0, occ_q} + {2'b00, infl_q}) <= 3'd1);
  assign accept = Rx_mac_pa & infl_q;
  assign head_v = occ_q != 2'd0;
  assign Rx_byte_abort = head_v & abt_q[rd_q];
  assign Rx_byte_valid = head_v & ~abt_q[rd_q];
  assign Rx_byte_data = dat_q[rd_q][{~idx_q, 3'b000} +: 8];
  assign Rx_byte_sop = Rx_byte_valid & sop_q[rd_q] & (idx_q == 2'd0);
  assign Rx_byte_eop = Rx_byte_valid & eop_q[rd_q] & (idx_q == nbm1_q[rd_q]);
  assign fire = Rx_byte_valid & Rx_byte_ready;
  assign pop = fire & (idx_q == nbm1_q[rd_q]);
  assign Rx_frame_len = flen_q;
  assign Rx_frame_len_valid = flv_q;
  assign Rx_err_cnt = err_q;
  // A sop inside an open frame starts the new frame and tags it so the old one is aborted downstream
  always_comb begin
    state_d = state_q;
    push = 1'b0;
    push_abt = 1'b0;
    err_inc = 1'b0;
    if (accept) begin
      if (Rx_mac_sop) begin
        push = 1'b1;
        push_abt = state_q == IN_FRAME;
        err_inc = state_q == IN_FRAME;
        state_d = Rx_mac_eop ? WAIT_SOP : IN_FRAME;
      end else if (state_q == IN_FRAME) begin
        push = 1'b1;
        state_d = Rx_mac_eop ? WAIT_SOP : IN_FRAME;
      end else begin
        err_inc = state_q == WAIT_SOP;
        state_d = (state_q == DISCARD && Rx_mac_eop) ? WAIT_SOP : DISCARD;
      end
    end
  end
  // BE-1 in two bits maps 00 to 3, giving nbytes-1 directly
  always_comb begin
    dat_d = dat_q;
    nbm1_d = nbm1_q;
    sop_d = sop_q;
    eop_d = eop_q;
    abt_d = abt_q;
    if (push) begin
      dat_d[wr_q] = Rx_mac_data;
      nbm1_d[wr_q] = Rx_mac_eop ? Rx_mac_BE - 2'd1 : 2'd3;
      sop_d[wr_q] = Rx_mac_sop;
      eop_d[wr_q] = Rx_mac_eop;
      abt_d[wr_q] = push_abt;
    end
    if (Rx_byte_abort) abt_d[rd_q] = 1'b0;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    idx_d = pop ? 2'd0 : fire ? idx_q + 2'd1 : idx_q;
    len_nxt = Rx_byte_sop ? 16'd1 : (&len_q ? len_q : len_q + 16'd1);
    len_d = Rx_byte_abort ? 16'd0 : fire ? len_nxt : len_q;
    flv_d = fire & Rx_byte_eop;
    flen_d = flv_d ? len_nxt : flen_q;
    err_d = (err_inc & ~&err_q) ? err_q + 16'd1 : err_q;
  end
  always_ff @(posedge Clk_user) begin
    if (Reset) begin
      state_q <= WAIT_SOP;
      occ_q <= 2'd0;
      infl_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      idx_q <= 2'd0;
      dat_q <= '{default: '0};
      nbm1_q <= '{default: '0};
      sop_q <= 2'd0;
      eop_q <= 2'd0;
      abt_q <= 2'd0;
      len_q <= 16'd0;
      flen_q <= 16'd0;
      flv_q <= 1'b0;
      err_q <= 16'd0;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      infl_q <= Rx_mac_rd;
      wr_q <= wr_d;
      rd_q <= rd_d;
      idx_q <= idx_d;
      dat_q <= dat_d;
      nbm1_q <= nbm1_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      abt_q <= abt_d;
      len_q <= len_d;
      flen_q <= flen_d;
      flv_q <= flv_d;
      err_q <= err_d;
    end
  end
endmodule
